adder_sched: RTL and testbench

ADDER_SCHED -- requirements
Module: adder_sched

---
 rtl/adder_sched.sv | 116 +++++++++++
 tb/tb_adder_sched.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_sched.sv
// Two-requester scheduler sharing one N-bit adder, with a registered result slot.
// Define ADDER_SCHED_RR_EN for round-robin arbitration; fixed priority (req0) otherwise.

module adder_n #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out
);

    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c_in};

endmodule

module adder_sched #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic         req0_c_in,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic         req1_c_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_sum,
    output logic         out_c_out,
    output logic         out_id
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t       state, state_nxt;
    logic         can_accept;
    logic         grant1;
    logic         xfer;
    logic [N-1:0] mux_a, mux_b;
    logic         mux_c_in;
    logic [N-1:0] add_sum;
    logic         add_c_out;

`ifdef ADDER_SCHED_RR_EN
    logic last_grant;

    // On a tie, favour whichever requester was not served last.
    always_comb begin
        grant1 = req1_valid && (!req0_valid || !last_grant);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (xfer) begin
            last_grant <= grant1;
        end
    end
`else
    always_comb begin
        grant1 = req1_valid && !req0_valid;
    end
`endif

    always_comb begin
        can_accept = (state == EMPTY) || out_ready;
        req0_ready = !rst && can_accept && req0_valid && !grant1;
        req1_ready = !rst && can_accept && grant1;
        xfer       = req0_ready || req1_ready;

        mux_a      = grant1 ? req1_a    : req0_a;
        mux_b      = grant1 ? req1_b    : req0_b;
        mux_c_in   = grant1 ? req1_c_in : req0_c_in;

        state_nxt = state;
        if (xfer) begin
            state_nxt = FULL;
        end else if (state == FULL && out_ready) begin
            state_nxt = EMPTY;
        end
    end

    adder_n #(.N(N)) u_adder (
        .a     (mux_a),
        .b     (mux_b),
        .c_in  (mux_c_in),
        .sum   (add_sum),
        .c_out (add_c_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            out_sum   <= '0;
            out_c_out <= 1'b0;
            out_id    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (xfer) begin
                out_sum   <= add_sum;
                out_c_out <= add_c_out;
                out_id    <= grant1;
            end
        end
    end

    assign out_valid = (state == FULL);

endmodule

// File: tb/tb_adder_sched.sv
// Self-checking bench for adder_sched: directed vector table, multi-cycle corner
// sequences and a randomized scoreboard run (expectations follow ADDER_SCHED_RR_EN).

module tb_adder_sched;

    localparam int unsigned N = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req0_c_in;
    logic [N-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_c_in;
    logic [N-1:0] req1_a, req1_b;
    logic         out_valid, out_ready, out_c_out, out_id;
    logic [N-1:0] out_sum;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    adder_sched #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_c_in  (req0_c_in),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_c_in  (req1_c_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_c_out  (out_c_out),
        .out_id     (out_id)
    );

    typedef struct {
        logic         v0;
        logic [N-1:0] a0, b0;
        logic         c0;
        logic         v1;
        logic [N-1:0] a1, b1;
        logic         c1;
        logic         e_rdy0, e_rdy1;
        logic         e_valid;
        logic [N-1:0] e_sum;
        logic         e_cout;
        logic         e_id;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v0, input logic [N-1:0] a0, input logic [N-1:0] b0,
                         input logic c0, input logic v1, input logic [N-1:0] a1,
                         input logic [N-1:0] b1, input logic c1);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_c_in = c0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_c_in = c1;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] sum;
        logic         cout;
        logic         id;
    } res_t;

    res_t         sb[$];
    res_t         r, e;
    logic [N:0]   wide;
    logic [N-1:0] held_sum;
    logic         exp_ids[4];
    int           accepted;
    int           cycles;

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'd1, 32'd1, 1'b0, 1'b1, 32'd2, 32'd2, 1'b0);

        // Reset: readys suppressed while rst high, outputs cleared.
        #2;
        chk("rst_ready0", {63'd0, req0_ready}, 64'd0);
        chk("rst_ready1", {63'd0, req1_ready}, 64'd0);
        tick();
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_sum", {32'd0, out_sum}, 64'd0);
        chk("rst_cout", {63'd0, out_c_out}, 64'd0);
        chk("rst_id", {63'd0, out_id}, 64'd0);
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        tick();

        vecs[0] = '{1, 32'd0, 32'd238467, 0, 0, 32'd0, 32'd0, 0, 1, 0, 1, 32'h0003A383, 0, 0};
        vecs[1] = '{0, 32'd0, 32'd0, 0, 1, 32'hFFFFFFFB, 32'd14, 1, 0, 1, 1, 32'h0000000A, 1, 1};
        vecs[2] = '{1, 32'd1, 32'd2, 0, 1, 32'd7, 32'd8, 0, 1, 0, 1, 32'd3, 0, 0};
`ifdef ADDER_SCHED_RR_EN
        vecs[3] = '{1, 32'd5, 32'd5, 1, 1, 32'd7, 32'd8, 0, 0, 1, 1, 32'd15, 0, 1};
`else
        vecs[3] = '{1, 32'd5, 32'd5, 1, 1, 32'd7, 32'd8, 0, 1, 0, 1, 32'd11, 0, 0};
`endif
        vecs[4] = '{1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 32'd0, 32'd0, 0, 1, 0, 1, 32'hFFFFFFFF, 1, 0};
        vecs[5] = '{1, 32'hFFFFFFFF, 32'd1, 0, 0, 32'd0, 32'd0, 0, 1, 0, 1, 32'd0, 1, 0};
        vecs[6] = '{0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0, 0, 0, 0, 0, 32'd0, 1, 0};

        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].v0, vecs[i].a0, vecs[i].b0, vecs[i].c0,
                  vecs[i].v1, vecs[i].a1, vecs[i].b1, vecs[i].c1);
            #2;
            chk($sformatf("v%0d_ready0", i), {63'd0, req0_ready}, {63'd0, vecs[i].e_rdy0});
            chk($sformatf("v%0d_ready1", i), {63'd0, req1_ready}, {63'd0, vecs[i].e_rdy1});
            tick();
            chk($sformatf("v%0d_valid", i), {63'd0, out_valid}, {63'd0, vecs[i].e_valid});
            chk($sformatf("v%0d_sum", i), {32'd0, out_sum}, {32'd0, vecs[i].e_sum});
            chk($sformatf("v%0d_cout", i), {63'd0, out_c_out}, {63'd0, vecs[i].e_cout});
            chk($sformatf("v%0d_id", i), {63'd0, out_id}, {63'd0, vecs[i].e_id});
        end

        // Backpressure: result held, readys low; release loads new result with no bubble.
        drive(1'b1, 32'd10, 32'd20, 1'b0, 1'b0, '0, '0, 1'b0);
        out_ready = 1'b1;
        tick();
        chk("bp_load_sum", {32'd0, out_sum}, 64'd30);
        out_ready = 1'b0;
        drive(1'b1, 32'd100, 32'd200, 1'b0, 1'b1, 32'd1, 32'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #2;
            chk("bp_ready0", {63'd0, req0_ready}, 64'd0);
            chk("bp_ready1", {63'd0, req1_ready}, 64'd0);
            tick();
            chk("bp_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_sum", {32'd0, out_sum}, 64'd30);
            chk("bp_id", {63'd0, out_id}, 64'd0);
        end
        req1_valid = 1'b0;
        out_ready = 1'b1;
        #2;
        chk("bp_release_ready0", {63'd0, req0_ready}, 64'd1);
        tick();
        chk("bp_release_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_release_sum", {32'd0, out_sum}, 64'd300);
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        tick();

        // Contention after reset.
        do_reset();
`ifdef ADDER_SCHED_RR_EN
        exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_ids = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        out_ready = 1'b1;
        drive(1'b1, 32'd3, 32'd4, 1'b0, 1'b1, 32'd5, 32'd6, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("cont%0d_id", i), {63'd0, out_id}, {63'd0, exp_ids[i]});
            chk($sformatf("cont%0d_sum", i), {32'd0, out_sum}, exp_ids[i] ? 64'd12 : 64'd7);
        end

        // Reset while FULL under backpressure discards the result.
        drive(1'b1, 32'd1, 32'd1, 1'b0, 1'b0, '0, '0, 1'b0);
        tick();
        out_ready = 1'b0;
        tick();
        chk("mr_full", {63'd0, out_valid}, 64'd1);
        rst = 1'b1;
        req1_valid = 1'b1;
        #2;
        chk("mr_ready0", {63'd0, req0_ready}, 64'd0);
        chk("mr_ready1", {63'd0, req1_ready}, 64'd0);
        tick();
        rst = 1'b0;
        chk("mr_valid", {63'd0, out_valid}, 64'd0);
        chk("mr_sum", {32'd0, out_sum}, 64'd0);
        out_ready = 1'b1;
        #2;
        chk("mr_tie_ready0", {63'd0, req0_ready}, 64'd1);
        chk("mr_tie_ready1", {63'd0, req1_ready}, 64'd0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        tick();
        tick();

        // Random traffic checked against an in-order scoreboard.
        accepted = 0;
        cycles = 0;
        while ((accepted < 1000 || sb.size() != 0) && cycles < 20000) begin
            if (accepted < 1000) begin
                drive($urandom_range(0, 1) == 1, $urandom, $urandom, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 1) == 1, $urandom, $urandom, $urandom_range(0, 1) == 1);
            end else begin
                drive(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
            end
            out_ready = $urandom_range(0, 3) != 0;
            #2;
            if (req0_ready && req1_ready) begin
                chk("rnd_one_ready", 64'd1, 64'd0);
            end
            if (req0_ready && !req0_valid) chk("rnd_ready0_no_valid", 64'd1, 64'd0);
            if (req1_ready && !req1_valid) chk("rnd_ready1_no_valid", 64'd1, 64'd0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("rnd_unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rnd_sum", {32'd0, out_sum}, {32'd0, e.sum});
                    chk("rnd_cout", {63'd0, out_c_out}, {63'd0, e.cout});
                    chk("rnd_id", {63'd0, out_id}, {63'd0, e.id});
                end
            end
            if (out_valid && !out_ready) held_sum = out_sum;
            if (req0_ready) begin
                wide = {1'b0, req0_a} + {1'b0, req0_b} + {32'd0, req0_c_in};
                r.sum = wide[N-1:0]; r.cout = wide[N]; r.id = 1'b0;
                sb.push_back(r);
                accepted++;
            end
            if (req1_ready) begin
                wide = {1'b0, req1_a} + {1'b0, req1_b} + {32'd0, req1_c_in};
                r.sum = wide[N-1:0]; r.cout = wide[N]; r.id = 1'b1;
                sb.push_back(r);
                accepted++;
            end
            tick();
            cycles++;
        end
        chk("rnd_all_accepted", (accepted >= 1000) ? 64'd1 : 64'd0, 64'd1);
        chk("rnd_sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
